pipelined_array_mul: RTL

//  Parametrised, pipelined unsigned array multiplier with a valid/ready stream handshake.

---
 rtl/pipelined_array_mul.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pipelined_array_mul.sv
// Pipelined array multiplier: partial-product rows are spread over STAGES register stages.
// Define SIGNED_MODE_EN to add the in_signed port and Baugh-Wooley two's-complement support.
module pipelined_array_mul #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SIGNED_MODE_EN
  input  logic               in_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int R  = (WIDTH + STAGES - 1) / STAGES;
  localparam int PW = 2 * WIDTH;

  // Row j of the array, shifted into place. In signed mode the sign-column
  // terms (and the whole MSB row except its corner bit) are inverted.
  function automatic logic [PW-1:0] row_term(input logic [WIDTH-1:0] op_a,
                                             input logic bit_b,
                                             input logic sgn,
                                             input int j);
    logic [WIDTH-1:0] r;
    r = op_a & {WIDTH{bit_b}};
    if (sgn) begin
      if (j == WIDTH - 1) r[WIDTH-2:0] = ~r[WIDTH-2:0];
      else r[WIDTH-1] = ~r[WIDTH-1];
    end
    return PW'(r) << j;
  endfunction

  function automatic logic [PW-1:0] add_rows(input logic [PW-1:0] sum,
                                             input logic [WIDTH-1:0] op_a,
                                             input logic [WIDTH-1:0] op_b,
                                             input logic sgn,
                                             input int k);
    logic [PW-1:0] s;
    s = sum;
    for (int j = 0; j < WIDTH; j++) begin
      if (j / R == k) s = s + row_term(op_a, op_b[j], sgn, j);
    end
    return s;
  endfunction

  logic             v_q     [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [PW-1:0]    s_q     [STAGES];
  logic [PW-1:0]    sum_nxt [STAGES];
  logic             stage_sgn [STAGES];
  logic [PW-1:0]    init_sum;
  logic             adv;

  // Handshake: a pair transfers on an edge with in_valid & in_ready, a product
  // with out_valid & out_ready. The pipe moves as one unit, so the input side
  // is ready exactly when the last stage is empty or being drained.
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[STAGES-1];
  assign product   = s_q[STAGES-1];

`ifdef SIGNED_MODE_EN
  localparam logic [PW-1:0] CORR = (PW'(1) << (PW - 1)) | (PW'(1) << WIDTH);
  logic sg_q [STAGES];
  assign init_sum = stage_sgn[0] ? CORR : '0;
`else
  assign init_sum = '0;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
`ifdef SIGNED_MODE_EN
      assign stage_sgn[k] = in_signed;
`else
      assign stage_sgn[k] = 1'b0;
`endif
      assign sum_nxt[k] = add_rows(init_sum, a, b, stage_sgn[k], k);
    end else begin : g_rest
`ifdef SIGNED_MODE_EN
      assign stage_sgn[k] = sg_q[k-1];
`else
      assign stage_sgn[k] = 1'b0;
`endif
      assign sum_nxt[k] = add_rows(s_q[k-1], a_q[k-1], b_q[k-1], stage_sgn[k], k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]  <= 1'b0;
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        s_q[k]  <= '0;
`ifdef SIGNED_MODE_EN
        sg_q[k] <= 1'b0;
`endif
      end
    end else if (adv) begin
      v_q[0]  <= in_valid;
      a_q[0]  <= a;
      b_q[0]  <= b;
      s_q[0]  <= sum_nxt[0];
`ifdef SIGNED_MODE_EN
      sg_q[0] <= in_signed;
`endif
      for (int k = 1; k < STAGES; k++) begin
        v_q[k]  <= v_q[k-1];
        a_q[k]  <= a_q[k-1];
        b_q[k]  <= b_q[k-1];
        s_q[k]  <= sum_nxt[k];
`ifdef SIGNED_MODE_EN
        sg_q[k] <= sg_q[k-1];
`endif
      end
    end
  end

endmodule
